// File: rtl/cam_tag_unit.sv
// Tag register and multiple-response resolver for the CAM array.
// Tags and status (some/first/count) update together on the op edge.
module cam_tag_unit #(
  parameter int WORDS = 100,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WORDS-1:0] match_lines,
  input  logic [2:0]       op,
  input  logic             op_valid,
  output logic [WORDS-1:0] tags,
  output logic             some,
  output logic [IDX_W-1:0] first_idx,
  output logic [IDX_W:0]   count,
  output logic             retired_valid,
  output logic [IDX_W-1:0] retired_idx
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_CLEAR = 3'd4,
    OP_SET   = 3'd5,
    OP_SEL   = 3'd6,
    OP_NEXT  = 3'd7
  } op_e;

  localparam int CW = IDX_W + 1;

  logic [WORDS-1:0] tags_q, tags_d;
  logic [WORDS-1:0] pre, low;
  logic             some_q, some_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rv_q, rv_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic             acc;

  // pre[i] = any tag below i; low = lowest set tag only
  always_comb begin
    acc = 1'b0;
    pre = '0;
    for (int i = 0; i < WORDS; i++) begin
      pre[i] = acc;
      acc    = acc | tags_q[i];
    end
    low = tags_q & ~pre;
  end

  always_comb begin
    tags_d = tags_q;
    rv_d   = 1'b0;
    ridx_d = ridx_q;
    if (op_valid) begin
      case (op_e'(op))
        OP_NOP:   tags_d = tags_q;
        OP_LOAD:  tags_d = match_lines;
        OP_AND:   tags_d = tags_q & match_lines;
        OP_OR:    tags_d = tags_q | match_lines;
        OP_CLEAR: tags_d = '0;
        OP_SET:   tags_d = '1;
        OP_SEL:   tags_d = low;
        OP_NEXT: begin
          if (some_q) begin
            tags_d = tags_q & pre;
            rv_d   = 1'b1;
            ridx_d = first_q;
          end
        end
        default:  tags_d = tags_q;
      endcase
    end
  end

  always_comb begin
    some_d  = |tags_d;
    first_d = '0;
    cnt_d   = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (tags_d[i]) first_d = IDX_W'(i);
    end
    for (int i = 0; i < WORDS; i++) begin
      cnt_d = cnt_d + CW'(tags_d[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tags_q  <= '0;
      some_q  <= 1'b0;
      first_q <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      ridx_q  <= '0;
    end else begin
      tags_q  <= tags_d;
      some_q  <= some_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      ridx_q  <= ridx_d;
    end
  end

  assign tags          = tags_q;
  assign some          = some_q;
  assign first_idx     = first_q;
  assign count         = cnt_q;
  assign retired_valid = rv_q;
  assign retired_idx   = ridx_q;

endmodule
